// File: rtl/edge_pkg.sv
// Shared definitions for the edge generator / detector family.
//
// Contents:
//   state_t          - FSM state encoding for the level generator.
//   req_t            - decoded edge request.
//   decode_req()     - priority decode of the raw request pulses
//                      (fall over rise over toggle).
//   DEFAULT_MIN_HOLD - default minimum stable time, in cycles.
//   HOLD_W           - width of the hold timer (MIN_HOLD is at most 255).
package edge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_FALL = 2'd1,
    REQ_RISE = 2'd2,
    REQ_TOG  = 2'd3
  } req_t;

  localparam int DEFAULT_MIN_HOLD = 4;
  localparam int HOLD_W           = 8;

  // Only the highest-priority pulse of a cycle survives; the others are
  // treated as if they never arrived.
  function automatic req_t decode_req(input logic fall, input logic rise,
                                      input logic tog);
    req_t r;
    r = REQ_NONE;
    if (fall)      r = REQ_FALL;
    else if (rise) r = REQ_RISE;
    else if (tog)  r = REQ_TOG;
    return r;
  endfunction

endpackage

// File: rtl/pulse_to_level_gen_hold_timer.sv
// hold_timer: loadable down-counter that stops at zero.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (count -> 0)
//   load      - load load_val this cycle (wins over decrement)
//   load_val  - value to load
//   done      - count is zero
//   busy      - count is non-zero
module hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done,
  output logic         busy
);

  logic [W-1:0] count;

  // Count down towards zero and park there until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign done = (count == '0);
  assign busy = (count != '0);

endmodule

// File: rtl/pulse_to_level_gen.sv
// pulse_to_level_gen: turns single-cycle rise/fall/toggle request pulses into
// a registered level, keeping at least MIN_HOLD cycles between edges.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - accept new requests (a pending change completes anyway)
//   rise_req     - request level 1
//   fall_req     - request level 0 (highest priority)
//   tog_req      - request the inverse of the current target
//   clr_cnt      - synchronous clear of drop_cnt
//   sig_out      - generated level
//   edge_stb     - one-cycle strobe in the cycle sig_out takes a new value
//   rise_stb     - edge_stb for 0->1 edges
//   fall_stb     - edge_stb for 1->0 edges
//   busy         - in the hold period after an edge
//   drop_cnt     - saturating count of requests that produced no edge of
//                  their own
module pulse_to_level_gen
  import edge_pkg::*;
#(
  parameter int   MIN_HOLD   = DEFAULT_MIN_HOLD,
  parameter logic INIT_LEVEL = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rise_req,
  input  logic             fall_req,
  input  logic             tog_req,
  input  logic             clr_cnt,
  output logic             sig_out,
  output logic             edge_stb,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  // With MIN_HOLD=1 an edge needs no hold period, so HOLD is never entered.
  localparam bit HOLD_USED = (MIN_HOLD > 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);

  state_t state;
  state_t next_state;
  logic   target;
  logic   next_target;
  req_t   req;
  logic   req_valid;
  logic   req_level;
  logic   drop_hit;
  logic   fire;
  logic   timer_done;
  logic   timer_busy;

  hold_timer #(.W(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (fire),
    .load_val (HOLD_LOAD),
    .done     (timer_done),
    .busy     (timer_busy)
  );

  // Decode the request and work out whether sig_out moves at this edge.
  // The timer is zero whenever the FSM is idle and in the last hold cycle,
  // so "timer done" is exactly the moment a change may be issued; using the
  // post-request target lets a request in that last cycle take effect at once.
  always_comb begin
    req        = en ? decode_req(fall_req, rise_req, tog_req) : REQ_NONE;
    req_valid  = (req != REQ_NONE);
    case (req)
      REQ_FALL: req_level = 1'b0;
      REQ_RISE: req_level = 1'b1;
      default:  req_level = ~target;
    endcase
    next_target = req_valid ? req_level : target;
    // Redundant request, or one that overwrites/cancels a pending change.
    drop_hit    = req_valid && ((req_level == target) || (target != sig_out));
    fire        = timer_done && (next_target != sig_out);
    if (fire)
      next_state = HOLD_USED ? HOLD : IDLE;
    else
      next_state = timer_busy ? HOLD : IDLE;
  end

  // Level, target, FSM state and strobes all update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      target   <= INIT_LEVEL;
      sig_out  <= INIT_LEVEL;
      edge_stb <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      state    <= next_state;
      target   <= next_target;
      if (fire)
        sig_out <= next_target;
      edge_stb <= fire;
      rise_stb <= fire & next_target;
      fall_stb <= fire & ~next_target;
    end
  end

  // Saturating drop counter; a clear beats an increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if (clr_cnt)
      drop_cnt <= '0;
    else if (drop_hit && (drop_cnt != '1))
      drop_cnt <= drop_cnt + CNT_W'(1);
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_pulse_to_level_gen.sv
module tb_pulse_to_level_gen;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_en, a_rise, a_fall, a_tog, a_clr;
  logic       a_sig, a_edge, a_rise_stb, a_fall_stb, a_busy;
  logic [7:0] a_drop;

  logic       b_en, b_rise, b_fall, b_tog, b_clr;
  logic       b_sig, b_edge, b_rise_stb, b_fall_stb, b_busy;
  logic [1:0] b_drop;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  pulse_to_level_gen #(.MIN_HOLD(4), .INIT_LEVEL(1'b0), .CNT_W(8)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (a_en),
    .rise_req (a_rise),
    .fall_req (a_fall),
    .tog_req  (a_tog),
    .clr_cnt  (a_clr),
    .sig_out  (a_sig),
    .edge_stb (a_edge),
    .rise_stb (a_rise_stb),
    .fall_stb (a_fall_stb),
    .busy     (a_busy),
    .drop_cnt (a_drop)
  );

  pulse_to_level_gen #(.MIN_HOLD(1), .INIT_LEVEL(1'b0), .CNT_W(2)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (b_en),
    .rise_req (b_rise),
    .fall_req (b_fall),
    .tog_req  (b_tog),
    .clr_cnt  (b_clr),
    .sig_out  (b_sig),
    .edge_stb (b_edge),
    .rise_stb (b_rise_stb),
    .fall_stb (b_fall_stb),
    .busy     (b_busy),
    .drop_cnt (b_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic f, input logic r, input logic t);
    a_fall = f;
    a_rise = r;
    a_tog  = t;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkA(input string tag, input logic s, input logic e,
                        input logic r, input logic f, input logic b,
                        input int d);
    checkOutput({tag, "/sig"},  8'(a_sig),      8'(s));
    checkOutput({tag, "/edge"}, 8'(a_edge),     8'(e));
    checkOutput({tag, "/rise"}, 8'(a_rise_stb), 8'(r));
    checkOutput({tag, "/fall"}, 8'(a_fall_stb), 8'(f));
    checkOutput({tag, "/busy"}, 8'(a_busy),     8'(b));
    checkOutput({tag, "/drop"}, a_drop,         8'(d));
  endtask

  task automatic checkB(input string tag, input logic s, input logic e,
                        input logic b, input int d);
    checkOutput({tag, "/sig"},  8'(b_sig),  8'(s));
    checkOutput({tag, "/edge"}, 8'(b_edge), 8'(e));
    checkOutput({tag, "/busy"}, 8'(b_busy), 8'(b));
    checkOutput({tag, "/drop"}, 8'(b_drop), 8'(d));
  endtask

  initial begin
    rst = 1'b1;
    a_en = 1'b1; a_clr = 1'b0;
    applyStimulus(0, 0, 0);
    b_en = 1'b1; b_rise = 1'b0; b_fall = 1'b0; b_tog = 1'b0; b_clr = 1'b0;
    tick(); tick();
    $display("[TB] reset values");
    checkA("reset", 0, 0, 0, 0, 0, 0);
    checkB("reset_b", 0, 0, 0, 0);
    rst = 1'b0;
    tick(); tick(); tick();

    // Toggle stream on the MIN_HOLD=1, CNT_W=2 instance
    $display("[TB] toggle stream, saturation, clear");
    b_tog = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkB($sformatf("tog%0d", i), 1'(i % 2), 1, 0, 0);
    end
    b_tog = 1'b0;
    b_rise = 1'b1;
    tick();
    checkB("b_rise", 1, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkB($sformatf("b_redundant%0d", k), 1, 0, 0, (k < 3) ? k : 3);
    end
    b_clr = 1'b1;
    tick();
    b_rise = 1'b0;
    b_clr  = 1'b0;
    checkB("b_clr_over_inc", 1, 0, 0, 0);

    // Rise then fall
    $display("[TB] rise then fall");
    applyStimulus(0, 1, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s1_rise11", 1, 1, 1, 0, 1, 0);
    tick();
    checkA("s1_hold12", 1, 0, 0, 0, 1, 0);
    tick(); tick();
    checkA("s1_hold14", 1, 0, 0, 0, 1, 0);
    tick();
    checkA("s1_idle15", 1, 0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s1_fall21", 0, 1, 0, 1, 1, 0);
    tick(); tick(); tick(); tick();
    checkA("s1_idle25", 0, 0, 0, 0, 0, 0);

    // Request during hold is deferred
    $display("[TB] request during hold");
    applyStimulus(0, 1, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s2_rise11", 1, 1, 1, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s2_defer13", 1, 0, 0, 0, 1, 0);
    tick();
    checkA("s2_defer14", 1, 0, 0, 0, 1, 0);
    tick();
    checkA("s2_fall15", 0, 1, 0, 1, 1, 0);
    tick(); tick(); tick(); tick();
    checkA("s2_idle19", 0, 0, 0, 0, 0, 0);

    // Cancelled pending change
    $display("[TB] cancelled pending change");
    applyStimulus(0, 1, 0); tick(); applyStimulus(0, 0, 0);
    tick();
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 1, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s3_hold14", 1, 0, 0, 0, 1, 1);
    tick();
    checkA("s3_noedge15", 1, 0, 0, 0, 0, 1);

    // Priority and redundancy
    $display("[TB] priority and redundancy");
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s4_fall", 0, 1, 0, 1, 1, 1);
    tick(); tick(); tick(); tick();
    applyStimulus(1, 1, 1); tick(); applyStimulus(0, 0, 0);
    checkA("s4_prio", 0, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 1); tick(); applyStimulus(0, 0, 0);
    checkA("s4_tog", 1, 1, 1, 0, 1, 2);
    tick(); tick(); tick(); tick();
    checkA("s4_idle", 1, 0, 0, 0, 0, 2);

    // Enable gating, pending change completing with en low
    $display("[TB] enable gating");
    a_en = 1'b0;
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s5_en0", 1, 0, 0, 0, 0, 2);
    a_en = 1'b1;
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s5_fall11", 0, 1, 0, 1, 1, 2);
    tick();
    applyStimulus(0, 1, 0); tick(); applyStimulus(0, 0, 0);
    a_en = 1'b0;
    tick(); tick();
    checkA("s5_pending15", 1, 1, 1, 0, 1, 2);
    a_en = 1'b1;
    tick(); tick(); tick(); tick();

    // Reset in the middle of a hold with a change pending
    $display("[TB] mid-hold reset");
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    tick(); tick(); tick(); tick();
    applyStimulus(0, 1, 0); tick(); applyStimulus(0, 0, 0);
    checkA("s6_rise11", 1, 1, 1, 0, 1, 2);
    tick();
    applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    rst = 1'b1;
    #1;
    checkA("s6_rst", 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    tick(); tick();
    checkA("s6_noedge15", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
